// File: rtl/restador_pkg.sv
// Shared definitions for the bit-serial subtractor.
//
// Contents:
//   state_t  - FSM encoding (IDLE = 1'b0, RESTA = 1'b1)
//   cntWidth - width of the bit counter, ceil(log2 n) + 1, so the
//              counter can hold the value n without wrapping
//
// Optional feature macro used by the files that import this package:
//   RESTADOR_SERIAL_OVF_EN - adds the signed overflow output
package restador_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        RESTA = 1'b1
    } state_t;

    function automatic int cntWidth(input int n);
        return $clog2(n) + 1;
    endfunction

endpackage

// File: rtl/restador_serial_completo.sv
// restadorCompleto: one combinational full-subtractor cell (a - b - bin).
//
// Ports:
//   a    in  1  minuend bit
//   b    in  1  subtrahend bit
//   bin  in  1  borrow in
//   d    out 1  difference bit
//   bout out 1  borrow out
//
// Macro: none (RESTADOR_SERIAL_OVF_EN only affects the top).
module restadorCompleto
    import restador_pkg::*;
(
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    logic w_x;

    // A borrow is generated when a=0,b=1, and propagated when a==b.
    assign w_x  = a ^ b;
    assign d    = w_x ^ bin;
    assign bout = (~a & b) | (~w_x & bin);

endmodule

// File: rtl/restador_serial.sv
// restador_serial: bit-serial N-bit subtractor, D = A - B, LSB first,
// one full-subtractor cell and a registered borrow.
//
// Ports:
//   clk   in  1  rising-edge clock
//   rst   in  1  asynchronous active-high reset
//   start in  1  request, sampled only while idle
//   a     in  N  minuend, captured on accepted start
//   b     in  N  subtrahend, captured on accepted start
//   busy  out 1  subtraction in progress
//   done  out 1  one-cycle pulse when d/bout are updated
//   d     out N  (A - B) mod 2^N, held between completions
//   bout  out 1  final borrow (unsigned A < B)
//   ovf   out 1  signed overflow, only with RESTADOR_SERIAL_OVF_EN
//
// Macro: RESTADOR_SERIAL_OVF_EN - adds the ovf port and its register.
module restador_serial
    import restador_pkg::*;
#(
    parameter int N = 4
)
(
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] d,
    output logic         bout
`ifdef RESTADOR_SERIAL_OVF_EN
    ,
    output logic         ovf
`endif
);

    localparam int            CW   = cntWidth(N);
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    state_t        r_state;
    state_t        w_stateNext;
    logic          w_load;
    logic          w_step;
    logic          w_last;

    logic [N-1:0]  r_opA;
    logic [N-1:0]  r_opB;
    logic [N-1:0]  r_work;
    logic [N-1:0]  r_d;
    logic          r_br;
    logic          r_bout;
    logic          r_done;
    logic [CW-1:0] r_cnt;

    logic          w_diff;
    logic          w_brNext;
    logic [N-1:0]  w_workNext;

`ifdef RESTADOR_SERIAL_OVF_EN
    logic          r_ovf;
`endif

    restadorCompleto uCelda (
        .a    (r_opA[0]),
        .b    (r_opB[0]),
        .bin  (r_br),
        .d    (w_diff),
        .bout (w_brNext)
    );

    // New difference bits enter at the MSB, so after N shifts the
    // first (LSB) result bit has reached position 0.
    assign w_workNext = {w_diff, r_work[N-1:1]};

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_stateNext;
        end
    end

    // Next state and datapath controls; the last step is the edge on
    // which the counter still reads N-1.
    always_comb begin
        w_stateNext = r_state;
        w_load      = 1'b0;
        w_step      = 1'b0;
        w_last      = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_load      = 1'b1;
                    w_stateNext = RESTA;
                end
            end
            RESTA: begin
                w_step = 1'b1;
                if (r_cnt == LAST) begin
                    w_last      = 1'b1;
                    w_stateNext = IDLE;
                end
            end
            default: w_stateNext = IDLE;
        endcase
    end

    // Operand shifting, borrow chain and result capture. Results are
    // only written on the final step, so d/bout stay stable otherwise.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_opA  <= '0;
            r_opB  <= '0;
            r_work <= '0;
            r_d    <= '0;
            r_br   <= 1'b0;
            r_bout <= 1'b0;
            r_done <= 1'b0;
            r_cnt  <= '0;
`ifdef RESTADOR_SERIAL_OVF_EN
            r_ovf  <= 1'b0;
`endif
        end else begin
            r_done <= 1'b0;
            if (w_load) begin
                r_opA  <= a;
                r_opB  <= b;
                r_work <= '0;
                r_br   <= 1'b0;
                r_cnt  <= '0;
            end else if (w_step) begin
                r_opA  <= r_opA >> 1;
                r_opB  <= r_opB >> 1;
                r_work <= w_workNext;
                r_br   <= w_brNext;
                r_cnt  <= r_cnt + CW'(1);
                if (w_last) begin
                    r_d    <= w_workNext;
                    r_bout <= w_brNext;
                    r_done <= 1'b1;
`ifdef RESTADOR_SERIAL_OVF_EN
                    // Borrow into the MSB differs from borrow out.
                    r_ovf  <= r_br ^ w_brNext;
`endif
                end
            end
        end
    end

    assign busy = (r_state == RESTA);
    assign done = r_done;
    assign d    = r_d;
    assign bout = r_bout;
`ifdef RESTADOR_SERIAL_OVF_EN
    assign ovf  = r_ovf;
`endif

endmodule

// File: tb/tb_restador_serial.sv
// Directed testbench for restador_serial (N = 4).
// Macro: RESTADOR_SERIAL_OVF_EN - also connects and checks ovf.
`timescale 1ns/1ps
module tb_restador_serial;

    localparam int N = 4;

    logic         clk;
    logic         rst;
    logic         start;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         busy;
    logic         done;
    logic [N-1:0] d;
    logic         bout;
`ifdef RESTADOR_SERIAL_OVF_EN
    logic         ovf;
`endif

    int vecCount  = 0;
    int missCount = 0;

    restador_serial #(.N(N)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .d     (d),
        .bout  (bout)
`ifdef RESTADOR_SERIAL_OVF_EN
        ,
        .ovf   (ovf)
`endif
    );

    // 10 ns clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Safety net so the run can never hang.
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    // Starts one operation and observes the window from the accept edge
    // to one edge past the expected completion. Results only, no checks.
    task automatic applyStimulus(input  logic [N-1:0] aIn,
                                 input  logic [N-1:0] bIn,
                                 output logic [N-1:0] gotD,
                                 output logic         gotBout,
                                 output logic         gotOvf,
                                 output int           busyCycles,
                                 output int           doneAt,
                                 output int           doneCount);
        a          = aIn;
        b          = bIn;
        start      = 1'b1;
        gotD       = '0;
        gotBout    = 1'b0;
        gotOvf     = 1'b0;
        busyCycles = 0;
        doneAt     = -1;
        doneCount  = 0;
        @(posedge clk);
        #1;
        start = 1'b0;
        a     = N'($urandom);
        b     = N'($urandom);
        for (int j = 0; j <= N + 1; j++) begin
            if (busy === 1'b1) busyCycles++;
            if (done === 1'b1) begin
                doneCount++;
                if (doneAt < 0) begin
                    doneAt  = j;
                    gotD    = d;
                    gotBout = bout;
`ifdef RESTADOR_SERIAL_OVF_EN
                    gotOvf  = ovf;
`endif
                end
            end
            if (j <= N) begin
                @(posedge clk);
                #1;
            end
        end
    endtask

    task automatic test_reset();
        rst   = 1'b1;
        start = 1'b0;
        a     = '0;
        b     = '0;
        #3;
        vecCount++;
        if ({busy, done, d, bout} !== '0) begin
            missCount++;
            $display("[TB] FAIL reset_outputs: got busy=%b done=%b d=%0d bout=%b, want all 0",
                     busy, done, d, bout);
        end
`ifdef RESTADOR_SERIAL_OVF_EN
        vecCount++;
        if (ovf !== 1'b0) begin
            missCount++;
            $display("[TB] FAIL reset_ovf: got %b, want 0", ovf);
        end
`endif
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_basic();
        logic [N-1:0] gd;
        logic         gb;
        logic         go;
        int           bc;
        int           da;
        int           dc;
        applyStimulus(4'd7, 4'd3, gd, gb, go, bc, da, dc);
        vecCount++;
        if (gd !== 4'd4) begin
            missCount++;
            $display("[TB] FAIL basic_d: got %0d, want 4", gd);
        end
        vecCount++;
        if (gb !== 1'b0) begin
            missCount++;
            $display("[TB] FAIL basic_bout: got %b, want 0", gb);
        end
        vecCount++;
        if (bc != N) begin
            missCount++;
            $display("[TB] FAIL basic_busy_cycles: got %0d, want %0d", bc, N);
        end
        vecCount++;
        if (da != N) begin
            missCount++;
            $display("[TB] FAIL basic_latency: got %0d, want %0d", da, N);
        end
        vecCount++;
        if (dc != 1) begin
            missCount++;
            $display("[TB] FAIL basic_done_pulses: got %0d, want 1", dc);
        end
    endtask

    task automatic test_table();
        logic [N-1:0] ta [3] = '{4'd3, 4'd0, 4'd15};
        logic [N-1:0] tb [3] = '{4'd7, 4'd0, 4'd15};
        logic [N-1:0] ed [3] = '{4'd12, 4'd0, 4'd0};
        logic         eb [3] = '{1'b1, 1'b0, 1'b0};
        logic [N-1:0] gd;
        logic         gb;
        logic         go;
        int           bc;
        int           da;
        int           dc;
        for (int i = 0; i < 3; i++) begin
            applyStimulus(ta[i], tb[i], gd, gb, go, bc, da, dc);
            vecCount++;
            if (gd !== ed[i] || da != N) begin
                missCount++;
                $display("[TB] FAIL table_d a=%0d b=%0d: got d=%0d at %0d, want %0d at %0d",
                         ta[i], tb[i], gd, da, ed[i], N);
            end
            vecCount++;
            if (gb !== eb[i]) begin
                missCount++;
                $display("[TB] FAIL table_bout a=%0d b=%0d: got %b, want %b",
                         ta[i], tb[i], gb, eb[i]);
            end
        end
    endtask

    // start held high, operands changing every cycle. Returning to IDLE
    // costs one cycle, so accepts land on edges 0, 5 and 10.
    task automatic test_back_to_back();
        logic [N-1:0] tabA [15] = '{4'd7, 4'd1, 4'd2, 4'd3, 4'd4, 4'd9, 4'd0, 4'd15,
                                    4'd6, 4'd5, 4'd12, 4'd3, 4'd3, 4'd3, 4'd3};
        logic [N-1:0] tabB [15] = '{4'd3, 4'd8, 4'd9, 4'd10, 4'd11, 4'd2, 4'd14, 4'd1,
                                    4'd13, 4'd12, 4'd13, 4'd0, 4'd0, 4'd0, 4'd0};
        int           expIdx [3] = '{4, 9, 14};
        logic [N-1:0] expD   [3] = '{4'd4, 4'd7, 4'd15};
        logic         expB   [3] = '{1'b0, 1'b0, 1'b1};
        int           doneIdx [3] = '{-1, -1, -1};
        logic [N-1:0] dAt     [3] = '{4'd0, 4'd0, 4'd0};
        logic         bAt     [3] = '{1'b0, 1'b0, 1'b0};
        int           nDone = 0;
        for (int c = 0; c < 15; c++) begin
            a     = tabA[c];
            b     = tabB[c];
            start = (c <= 10);
            @(posedge clk);
            #1;
            if (done === 1'b1) begin
                if (nDone < 3) begin
                    doneIdx[nDone] = c;
                    dAt[nDone]     = d;
                    bAt[nDone]     = bout;
                end
                nDone++;
            end
        end
        start = 1'b0;
        vecCount++;
        if (nDone != 3) begin
            missCount++;
            $display("[TB] FAIL b2b_done_count: got %0d, want 3", nDone);
        end
        for (int i = 0; i < 3; i++) begin
            vecCount++;
            if (doneIdx[i] != expIdx[i] || dAt[i] !== expD[i] || bAt[i] !== expB[i]) begin
                missCount++;
                $display("[TB] FAIL b2b_result%0d: got edge=%0d d=%0d bout=%b, want edge=%0d d=%0d bout=%b",
                         i, doneIdx[i], dAt[i], bAt[i], expIdx[i], expD[i], expB[i]);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset_abort();
        logic [N-1:0] gd;
        logic         gb;
        logic         go;
        int           bc;
        int           da;
        int           dc;
        int           lateDone = 0;
        applyStimulus(4'd9, 4'd1, gd, gb, go, bc, da, dc);
        vecCount++;
        if (gd !== 4'd8 || gb !== 1'b0) begin
            missCount++;
            $display("[TB] FAIL abort_setup: got d=%0d bout=%b, want d=8 bout=0", gd, gb);
        end
        a     = 4'd2;
        b     = 4'd5;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        vecCount++;
        if ({busy, done, d, bout} !== '0) begin
            missCount++;
            $display("[TB] FAIL abort_clear: got busy=%b done=%b d=%0d bout=%b, want all 0",
                     busy, done, d, bout);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int j = 0; j < N + 3; j++) begin
            @(posedge clk);
            #1;
            if (done === 1'b1 || busy === 1'b1) lateDone++;
        end
        vecCount++;
        if (lateDone != 0 || d !== 4'd0) begin
            missCount++;
            $display("[TB] FAIL abort_no_done: got %0d busy/done cycles, d=%0d, want 0 and 0",
                     lateDone, d);
        end
    endtask

`ifdef RESTADOR_SERIAL_OVF_EN
    task automatic test_ovf();
        logic [N-1:0] ta [3] = '{4'd7, 4'd8, 4'd5};
        logic [N-1:0] tb [3] = '{4'd15, 4'd1, 4'd2};
        logic [N-1:0] ed [3] = '{4'd8, 4'd7, 4'd3};
        logic         eb [3] = '{1'b1, 1'b0, 1'b0};
        logic         eo [3] = '{1'b1, 1'b1, 1'b0};
        logic [N-1:0] gd;
        logic         gb;
        logic         go;
        int           bc;
        int           da;
        int           dc;
        for (int i = 0; i < 3; i++) begin
            applyStimulus(ta[i], tb[i], gd, gb, go, bc, da, dc);
            vecCount++;
            if (gd !== ed[i] || gb !== eb[i] || go !== eo[i]) begin
                missCount++;
                $display("[TB] FAIL ovf a=%0d b=%0d: got d=%0d bout=%b ovf=%b, want d=%0d bout=%b ovf=%b",
                         ta[i], tb[i], gd, gb, go, ed[i], eb[i], eo[i]);
            end
        end
    endtask
`endif

    task automatic test_exhaustive();
        logic [N-1:0] gd;
        logic         gb;
        logic         go;
        int           bc;
        int           da;
        int           dc;
        logic [N-1:0] ea;
        logic [N-1:0] eb;
        logic [N-1:0] expD;
        for (int ia = 0; ia < 16; ia++) begin
            for (int ib = 0; ib < 16; ib++) begin
                ea   = N'(ia);
                eb   = N'(ib);
                expD = N'((ia - ib + 16) % 16);
                applyStimulus(ea, eb, gd, gb, go, bc, da, dc);
                vecCount++;
                if (gd !== expD || da != N) begin
                    missCount++;
                    $display("[TB] FAIL sweep_d a=%0d b=%0d: got %0d at %0d, want %0d at %0d",
                             ia, ib, gd, da, expD, N);
                end
                vecCount++;
                if (gb !== (ia < ib)) begin
                    missCount++;
                    $display("[TB] FAIL sweep_bout a=%0d b=%0d: got %b, want %b",
                             ia, ib, gb, (ia < ib));
                end
            end
        end
    endtask

    // Test sequence.
    initial begin
        test_reset();
        test_basic();
        test_table();
        test_back_to_back();
        test_reset_abort();
`ifdef RESTADOR_SERIAL_OVF_EN
        test_ovf();
`endif
        test_exhaustive();
        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end

endmodule
